spi_frame_ctrl: RTL and testbench
=================================

# spi_frame_ctrl

Sequencer for the SPI slave decoder that receives the Arduino command frames. It synchronizes the external `sclk`, `ss_n` and `mosi` pins into the `clk` domain and generates the one-cycle shift strobe that drives the decoder's `enable`. It counts exactly 16 bits per frame: 4 bits each for `Ain`, `oper`, `num2` and `num1`, MSB of `Ain` first. It then pulses `frame_done` so the ALU result and next-state FSM can consume the decoded fields, and it rejects short or overlong frames.

## Interface
- `FRAME_BITS`, 16, bits per frame; must equal the decoder shift depth
- `CNT_W`, 5, bit counter width; holds 0..`FRAME_BITS`
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `sclk` in 1: raw SPI clock from the master, asynchronous.
- `ss_n` in 1: raw slave select, active-low, asynchronous.
- `mosi` in 1: raw SPI data, asynchronous.
- `shift_en` out 1: one-cycle strobe. Wire it to the decoder `enable`.
- `mosi_q` out 1: synchronized data bit, valid whenever `shift_en`=1. Wire it to the decoder `mosi`.
- `frame_done` out 1: one-cycle pulse. The decoder fields are complete and stable.
- `frame_err` out 1: one-cycle pulse. The frame was short or overlong.
- `busy` out 1: high while a frame is in progress.
- `bit_cnt` out `CNT_W`: bits accepted in the current frame.
- `result` in 4: ALU result to return to the master. Present only with `SPI_MISO_EN`.
- `miso` out 1: reply data bit. Present only with `SPI_MISO_EN`.

## Operation
- Synchronizers: `sclk`, `ss_n` and `mosi` each pass through two flops. A third flop on `sclk` and on `ss_n` provides edge detection.
- `sclk` rising edge: synchronized `sclk` is 1 and the previous sample was 0.
- State `ARM`:
  - This is the reset state.
  - Stay here until synchronized `ss_n`=1, then go to `IDLE`.
  - This prevents accepting a partial frame when reset is released mid-transfer.
- State `IDLE`:
  - `bit_cnt`=0.
  - Synchronized `ss_n` falling → `SHIFT`.
- State `SHIFT`:
  - `busy`=1.
  - Each `sclk` rising edge with `bit_cnt`<`FRAME_BITS`: `shift_en`=1 for one cycle and `bit_cnt`+1.
  - `ss_n` rises with `bit_cnt`=`FRAME_BITS` → `DONE`.
  - `ss_n` rises with `bit_cnt`<`FRAME_BITS` → `ERR`.
  - `sclk` edge with `bit_cnt`=`FRAME_BITS`: no `shift_en` is issued and the sticky overrun bit is set. The decoder fields are never disturbed.
- State `DONE`:
  - Overrun bit clear: `frame_done`=1.
  - Overrun bit set: `frame_err`=1 instead.
  - Next state → `IDLE`.
- State `ERR`:
  - `frame_err`=1, then → `IDLE`.
  - The decoder holds whatever partial data it shifted in. Consumers must ignore it because no `frame_done` was issued.
- Simultaneous `ss_n` rise and `sclk` edge in the same cycle: `ss_n` wins and the edge is not counted.
- `bit_cnt` saturates at `FRAME_BITS` and never wraps.
- `rst`, including mid-frame: go to `ARM` next cycle, clear every counter, flag and output, and drop any pending strobe.
- Reset values: `shift_en`, `mosi_q`, `frame_done`, `frame_err`, `busy`, `miso` all 0; `bit_cnt`=0.

## Timing
- Latency from a `sclk` rising edge at the pin to `shift_en`: 3 `clk` cycles (2 synchronizer flops plus the edge register). `mosi_q` is aligned to the same cycle.
- The decoder registers update on the `clk` edge where `shift_en`=1.
- `frame_done`: 2 cycles after `ss_n` rise is seen synchronized. The decoder fields have been stable since the 16th strobe.
- The `sclk` high and low phases must each last at least 3 `clk` periods. Faster clocks are unsupported and edges may be missed.
- Minimum `ss_n` high time between frames: 3 `clk` cycles.

## Configuration
- Macro: `SPI_MISO_EN`.
- Defined:
  - On the `SHIFT` entry cycle, `result` is latched into a 4-bit reply register.
  - On each synchronized `sclk` falling edge in `SHIFT`, `miso` presents the next bit, MSB first.
  - After 4 bits, `miso`=0.
  - In every state other than `SHIFT`, `miso`=0.
  - The master therefore reads the previous frame's result during the current frame.
- Undefined: the `result` and `miso` ports, the reply register and the falling-edge detect are absent.

## Structure
- Package `spi_ctrl_pkg`:
  - `FRAME_BITS` default constant.
  - State enum `ARM`, `IDLE`, `SHIFT`, `DONE`, `ERR`.
  - Reply width constant (4).
- Sub-module `sync2`: a two-flop synchronizer with a synchronous reset value parameter. It is instantiated three times.

## Test plan
- Send frame 0xA5C3 with `ss_n` framing:
  - Exactly 16 `shift_en` pulses, `mosi_q` bits equal 1010_0101_1100_0011.
  - One `frame_done` pulse; decoder `Ain`=0xA, `oper`=0x5, `num2`=0xC, `num1`=0x3.
- Short frame, 9 edges then `ss_n` high:
  - 9 strobes, one `frame_err` pulse, no `frame_done`, `bit_cnt` returns to 0.
- Overlong frame, 18 edges:
  - Only 16 strobes and the decoder holds the first 16 bits.
  - `frame_err` pulse and no `frame_done`.
- Assert `rst` after 7 bits while `ss_n` stays low, then finish the frame:
  - No strobes until `ss_n` goes high.
  - The next full frame decodes correctly.
- `ss_n` rise coincident with the 16th `sclk` edge:
  - 15 strobes and `frame_err`.
- With `SPI_MISO_EN`, `result`=0x9 at frame start:
  - `miso` reads 1,0,0,1 on the first 4 falling edges, then 0.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg
// Shared constants and types for the SPI frame sequencer.
//   DEF_FRAME_BITS : default number of bits in one command frame
//   REPLY_W        : width of the reply word returned on miso
//   state_t        : sequencer states
// Optional reply path is controlled by the SPI_MISO_EN macro in the users.
package spi_ctrl_pkg;

  localparam int DEF_FRAME_BITS = 16;
  localparam int REPLY_W        = 4;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    SHIFT,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// spi_frame_ctrl_if
// Bundles the SPI pins and the decoder-side strobes of spi_frame_ctrl.
//   master modport : drives sclk/ss_n/mosi (and result), observes the rest
//   slave modport  : the sequencer itself
// Pins: sclk, ss_n, mosi (raw, asynchronous); shift_en, mosi_q, frame_done,
// frame_err, busy, bit_cnt (clk domain). With SPI_MISO_EN defined the
// result (reply word in) and miso (reply bit out) signals are added.
interface spi_frame_ctrl_if #(
  parameter int CNT_W = 5
);
  import spi_ctrl_pkg::*;

  logic             sclk;
  logic             ss_n;
  logic             mosi;
  logic             shift_en;
  logic             mosi_q;
  logic             frame_done;
  logic             frame_err;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
`ifdef SPI_MISO_EN
  logic [REPLY_W-1:0] result;
  logic               miso;

  modport master (
    output sclk, ss_n, mosi, result,
    input  shift_en, mosi_q, frame_done, frame_err, busy, bit_cnt, miso
  );

  modport slave (
    input  sclk, ss_n, mosi, result,
    output shift_en, mosi_q, frame_done, frame_err, busy, bit_cnt, miso
  );
`else
  modport master (
    output sclk, ss_n, mosi,
    input  shift_en, mosi_q, frame_done, frame_err, busy, bit_cnt
  );

  modport slave (
    input  sclk, ss_n, mosi,
    output shift_en, mosi_q, frame_done, frame_err, busy, bit_cnt
  );
`endif

endinterface

// File: rtl/spi_frame_ctrl_sync2.sv
// sync2
// Two-flop synchronizer for one asynchronous input bit.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output, RST_VAL while in reset
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl
// Frame sequencer for the SPI command decoder. Synchronizes sclk/ss_n/mosi,
// issues one shift_en strobe per sclk rising edge (at most FRAME_BITS per
// frame) and reports complete frames with frame_done, short or overlong
// frames with frame_err.
//   clk, rst : clock, synchronous active-high reset
//   bus      : spi_frame_ctrl_if.slave (pins + decoder strobes)
// Macro SPI_MISO_EN: adds a reply register latched from bus.result at frame
// start and shifted out MSB first on bus.miso at sclk falling edges.
module spi_frame_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CNT_W      = $clog2(DEF_FRAME_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  spi_frame_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  // Synchronizers, bit order {mosi, ss_n, sclk}. ss_n deliberately resets
  // to 0 ("selected"): coming out of reset mid-transfer must not look like
  // an idle bus, so ARM only leaves once a genuine high level is seen.
  logic [2:0] raw_vec;
  logic [2:0] sync_vec;

  assign raw_vec = {bus.mosi, bus.ss_n, bus.sclk};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync2 #(.RST_VAL(1'b0)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_vec[gi]),
        .q   (sync_vec[gi])
      );
    end
  endgenerate

  logic sclk_s, ss_s, mosi_s;
  logic sclk_d_reg, ss_d_reg;
  logic sclk_rise, ss_rise, ss_fall;

  assign sclk_s    = sync_vec[0];
  assign ss_s      = sync_vec[1];
  assign mosi_s    = sync_vec[2];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign ss_rise   = ss_s & ~ss_d_reg;
  assign ss_fall   = ~ss_s & ss_d_reg;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             ovr_reg, ovr_next;
  logic             shift_en_reg, shift_en_next;
  logic             mosi_q_reg, mosi_q_next;
  logic             frame_done_reg, frame_done_next;
  logic             frame_err_reg, frame_err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARM;
      bit_cnt_reg    <= '0;
      ovr_reg        <= 1'b0;
      shift_en_reg   <= 1'b0;
      mosi_q_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      sclk_d_reg     <= 1'b0;
      ss_d_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      ovr_reg        <= ovr_next;
      shift_en_reg   <= shift_en_next;
      mosi_q_reg     <= mosi_q_next;
      frame_done_reg <= frame_done_next;
      frame_err_reg  <= frame_err_next;
      sclk_d_reg     <= sclk_s;
      ss_d_reg       <= ss_s;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    ovr_next        = ovr_reg;
    shift_en_next   = 1'b0;
    mosi_q_next     = mosi_q_reg;
    frame_done_next = 1'b0;
    frame_err_next  = 1'b0;

    case (state_reg)
      ARM: begin
        if (ss_s) state_next = IDLE;
      end
      IDLE: begin
        bit_cnt_next = '0;
        ovr_next     = 1'b0;
        if (ss_fall) state_next = SHIFT;
      end
      SHIFT: begin
        // An ss_n rise masks a coincident sclk edge: the frame ends first.
        if (ss_rise) begin
          state_next = (bit_cnt_reg == FULL_CNT) ? DONE : ERR;
        end else if (sclk_rise) begin
          if (bit_cnt_reg < FULL_CNT) begin
            shift_en_next = 1'b1;
            mosi_q_next   = mosi_s;
            bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
          end else begin
            ovr_next = 1'b1;
          end
        end
      end
      DONE: begin
        frame_done_next = ~ovr_reg;
        frame_err_next  = ovr_reg;
        bit_cnt_next    = '0;
        state_next      = IDLE;
      end
      ERR: begin
        frame_err_next = 1'b1;
        bit_cnt_next   = '0;
        state_next     = IDLE;
      end
      default: state_next = ARM;
    endcase
  end

  assign bus.shift_en   = shift_en_reg;
  assign bus.mosi_q     = mosi_q_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.frame_err  = frame_err_reg;
  assign bus.busy       = (state_reg == SHIFT);
  assign bus.bit_cnt    = bit_cnt_reg;

`ifdef SPI_MISO_EN
  // Reply path: the word latched at frame start is shifted left on every
  // sclk falling edge; zeros fill in, so miso reads 0 after REPLY_W bits.
  logic               sclk_fall;
  logic [REPLY_W-1:0] reply_reg;
  logic               miso_reg;

  assign sclk_fall = ~sclk_s & sclk_d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      reply_reg <= '0;
      miso_reg  <= 1'b0;
    end else if (state_reg == IDLE && ss_fall) begin
      reply_reg <= bus.result;
      miso_reg  <= 1'b0;
    end else if (state_reg == SHIFT) begin
      if (sclk_fall) begin
        miso_reg  <= reply_reg[REPLY_W-1];
        reply_reg <= {reply_reg[REPLY_W-2:0], 1'b0};
      end
    end else begin
      miso_reg <= 1'b0;
    end
  end

  assign bus.miso = miso_reg;
`endif

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl
// Self-checking bench for spi_frame_ctrl: a table of directed frames plus
// hand-written sequences for reset, strobe latency and (with SPI_MISO_EN)
// the reply bits. A 16-bit shift register stands in for the decoder.
`timescale 1ns/1ps
module tb_spi_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_frame_ctrl_if #(.CNT_W(5)) bus ();

  spi_frame_ctrl #(.FRAME_BITS(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Running event counters and decoder model, sampled on the falling edge.
  int          strb_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic [15:0] dec_reg  = '0;

  always @(negedge clk) begin
    if (bus.shift_en === 1'b1) begin
      strb_cnt = strb_cnt + 1;
      dec_reg  = {dec_reg[14:0], bus.mosi_q};
    end
    if (bus.frame_done === 1'b1) done_cnt = done_cnt + 1;
    if (bus.frame_err === 1'b1)  err_cnt  = err_cnt + 1;
  end

  typedef struct {
    logic [31:0] data;
    int          nbits;
    bit          coin;      // ss_n rises together with the last sclk edge
    int          exp_strb;
    int          exp_done;
    int          exp_err;
    bit          chk_dec;
    logic [15:0] exp_dec;
    int          exp_cnt;   // bit_cnt just before ss_n rises, -1 = skip
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] data, input int n, input bit coin);
    for (int i = 0; i < n; i++) begin
      bus.mosi = data[n-1-i];
      wait_clk(4);
      bus.sclk = 1'b1;
      if (coin && i == n - 1) bus.ss_n = 1'b1;
      wait_clk(4);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic run_row(input vec_t v, input int idx);
    int s0, d0, e0;
    s0 = strb_cnt; d0 = done_cnt; e0 = err_cnt;
    bus.ss_n = 1'b0;
    wait_clk(4);
    send_bits(v.data, v.nbits, v.coin);
    if (!v.coin) begin
      wait_clk(4);
      if (v.exp_cnt >= 0) begin
        chk($sformatf("row%0d_cnt_end", idx), int'(bus.bit_cnt), v.exp_cnt);
        chk($sformatf("row%0d_busy", idx), int'(bus.busy), 1);
      end
      bus.ss_n = 1'b1;
    end
    wait_clk(10);
    chk($sformatf("row%0d_strobes", idx), strb_cnt - s0, v.exp_strb);
    chk($sformatf("row%0d_done", idx), done_cnt - d0, v.exp_done);
    chk($sformatf("row%0d_err", idx), err_cnt - e0, v.exp_err);
    if (v.chk_dec) chk($sformatf("row%0d_dec", idx), int'(dec_reg), int'(v.exp_dec));
    chk($sformatf("row%0d_cnt_idle", idx), int'(bus.bit_cnt), 0);
    chk($sformatf("row%0d_idle_busy", idx), int'(bus.busy), 0);
    $display("row %0d: data=%h bits=%0d strobes=%0d done=%0d err=%0d dec=%h",
             idx, v.data, v.nbits, strb_cnt - s0, done_cnt - d0, err_cnt - e0, dec_reg);
  endtask

  initial begin
    int s0, d0, e0;
    vec_t tail;

    vecs[0] = '{32'h0000A5C3, 16, 1'b0, 16, 1, 0, 1'b1, 16'hA5C3, 16};
    vecs[1] = '{32'h00000155,  9, 1'b0,  9, 0, 1, 1'b0, 16'h0000,  9};
    vecs[2] = '{32'h0000F25B, 18, 1'b0, 16, 0, 1, 1'b1, 16'h3C96, 16};
    vecs[3] = '{32'h00007E81, 16, 1'b1, 15, 0, 1, 1'b0, 16'h0000, -1};
    vecs[4] = '{32'h00000000, 16, 1'b0, 16, 1, 0, 1'b1, 16'h0000, 16};
    vecs[5] = '{32'h0000FFFF, 16, 1'b0, 16, 1, 0, 1'b1, 16'hFFFF, 16};
    tail    = '{32'h00001234, 16, 1'b0, 16, 1, 0, 1'b1, 16'h1234, 16};

    bus.sclk = 1'b0;
    bus.ss_n = 1'b1;
    bus.mosi = 1'b0;
`ifdef SPI_MISO_EN
    bus.result = 4'h0;
`endif

    // Reset state
    wait_clk(3);
    chk("rst_shift_en", int'(bus.shift_en), 0);
    chk("rst_mosi_q", int'(bus.mosi_q), 0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_bit_cnt", int'(bus.bit_cnt), 0);
    rst = 1'b0;
    wait_clk(6);
    $display("reset: released, bit_cnt=%0d busy=%0d", bus.bit_cnt, bus.busy);

    // Strobe latency: 3 clk from sclk rise at the pin to shift_en
    e0 = err_cnt;
    bus.ss_n = 1'b0;
    wait_clk(4);
    bus.mosi = 1'b1;
    bus.sclk = 1'b1;
    wait_clk(2);
    chk("lat_before", int'(bus.shift_en), 0);
    wait_clk(1);
    chk("lat_strobe", int'(bus.shift_en), 1);
    chk("lat_mosi_q", int'(bus.mosi_q), 1);
    wait_clk(3);
    bus.sclk = 1'b0;
    wait_clk(4);
    bus.ss_n = 1'b1;
    wait_clk(10);
    chk("lat_short_err", err_cnt - e0, 1);
    $display("latency: 1-bit frame, err pulses=%0d", err_cnt - e0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) run_row(vecs[i], i);

    // Reset after 7 bits with ss_n held low, then finish the frame
    bus.ss_n = 1'b0;
    wait_clk(4);
    send_bits(32'h55, 7, 1'b0);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_bit_cnt", int'(bus.bit_cnt), 0);
    chk("midrst_shift_en", int'(bus.shift_en), 0);
    s0 = strb_cnt; d0 = done_cnt; e0 = err_cnt;
    send_bits(32'h1A5, 9, 1'b0);
    wait_clk(4);
    chk("midrst_cnt_held", int'(bus.bit_cnt), 0);
    bus.ss_n = 1'b1;
    wait_clk(10);
    chk("midrst_strobes", strb_cnt - s0, 0);
    chk("midrst_done", done_cnt - d0, 0);
    chk("midrst_err", err_cnt - e0, 0);
    $display("midrst: strobes after reset=%0d done=%0d err=%0d",
             strb_cnt - s0, done_cnt - d0, err_cnt - e0);
    run_row(tail, 6);

`ifdef SPI_MISO_EN
    begin
      logic [5:0] exp_miso;
      exp_miso = 6'b100100;
      bus.result = 4'h9;
      bus.ss_n = 1'b0;
      wait_clk(4);
      for (int i = 0; i < 6; i++) begin
        bus.sclk = 1'b1;
        wait_clk(4);
        bus.sclk = 1'b0;
        wait_clk(4);
        chk($sformatf("miso_bit%0d", i), int'(bus.miso), int'(exp_miso[5-i]));
        $display("miso: fall %0d miso=%0d", i, bus.miso);
      end
      bus.ss_n = 1'b1;
      wait_clk(10);
      chk("miso_idle", int'(bus.miso), 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
